// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, error bit indices and oversample helpers for the UART receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  localparam int BRK = 0;
  localparam int PAR = 1;
  localparam int FRM = 2;
  localparam int OS_RATIO = 16;
  function automatic int os_ratio();
    return OS_RATIO;
  endfunction
  function automatic int os_div(input int sys, input int baud);
    int d = sys / (baud * OS_RATIO);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle oversample tick every DIV clocks, restartable so ticks align to a start edge.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic restart,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= cnt == LAST;
      cnt  <= cnt == LAST ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with even parity, break/frame/parity detection and FIFO push strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 Overrun,
  output logic                 RTS,
  output logic                 Rx_Busy
);
  localparam int OS_DIV = os_div(SYSCLK_RATE, BAUD_RATE);
  state_t               state;
  logic [1:0]           sync;
  logic                 rx_d, rx_s, fall, tick, restart, mid;
  logic                 brk_wait, all_zero, frm, par, brk_n, frm_n, last_stop;
  logic [3:0]           tcnt;
  logic [2:0]           bitcnt;
  logic                 stopcnt;
  logic [DATA_BITS-1:0] shift;

  assign rx_s      = sync[1];
  assign fall      = rx_d & ~rx_s;
  assign restart   = fall & ~brk_wait & (state == IDLE || state == DONE);
  assign mid       = tick & (tcnt == (state == START ? 4'd7 : 4'd15));
  assign brk_n     = all_zero & ~rx_s;
  assign frm_n     = frm | ~rx_s;
  assign last_stop = stopcnt == 1'(STOP_BITS - 1);
  assign Rx_Busy   = state != IDLE;

  uart_baud_tick #(.DIV(OS_DIV)) u_tick (.Clk(Clk), .Rst(Rst), .restart(restart), .tick(tick));

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state      <= IDLE;
      sync       <= 2'b11;
      rx_d       <= 1'b1;
      tcnt       <= '0;
      bitcnt     <= '0;
      stopcnt    <= 1'b0;
      shift      <= '0;
      brk_wait   <= 1'b0;
      all_zero   <= 1'b0;
      frm        <= 1'b0;
      par        <= 1'b0;
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Rx_Error   <= '0;
      Overrun    <= 1'b0;
      RTS        <= 1'b0;
    end else begin
      sync       <= {sync[0], Rx};
      rx_d       <= rx_s;
      RTS        <= ~FIFO_Full;
      Data_Valid <= 1'b0;
      Overrun    <= 1'b0;
      case (state)
        IDLE:
          if (brk_wait) begin
            // after a break, only a full bit time of idle-high line re-arms edge detection
            if (!rx_s) tcnt <= '0;
            else if (tick) begin
              tcnt <= tcnt + 1'b1;
              if (tcnt == 4'd15) brk_wait <= 1'b0;
            end
          end else if (fall) begin
            state <= START;
            tcnt  <= '0;
          end
        START:
          if (tick) begin
            tcnt <= mid ? 4'd0 : tcnt + 1'b1;
            if (mid) begin
              state    <= rx_s ? IDLE : DATA;
              Rx_Error <= rx_s ? Rx_Error : 3'b000;
              all_zero <= 1'b1;
              frm      <= 1'b0;
              par      <= 1'b0;
              bitcnt   <= '0;
            end
          end
        DATA:
          if (tick) begin
            tcnt <= tcnt + 1'b1;
            if (mid) begin
              shift    <= {shift[DATA_BITS-2:0], rx_s};
              all_zero <= brk_n;
              bitcnt   <= bitcnt + 1'b1;
              stopcnt  <= 1'b0;
              if (bitcnt == 3'(DATA_BITS - 1)) state <= PARITY_BIT != 0 ? PARITY : STOP;
            end
          end
        PARITY:
          if (tick) begin
            tcnt <= tcnt + 1'b1;
            if (mid) begin
              par      <= rx_s ^ (^shift);
              all_zero <= brk_n;
              state    <= STOP;
            end
          end
        STOP:
          if (tick) begin
            tcnt <= tcnt + 1'b1;
            if (mid) begin
              frm      <= frm_n;
              all_zero <= brk_n;
              stopcnt  <= stopcnt + 1'b1;
              if (last_stop) begin
                state         <= DONE;
                Data_Out      <= shift;
                Rx_Error[BRK] <= brk_n;
                Rx_Error[PAR] <= par & ~brk_n;
                Rx_Error[FRM] <= frm_n & ~brk_n;
                Data_Valid    <= ~FIFO_Full;
                Overrun       <= FIFO_Full;
                brk_wait      <= brk_n;
              end
            end
          end
        DONE: begin
          tcnt  <= '0;
          state <= restart ? START : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames; expected words queued by the driver, checked by a strobe monitor.
module tb_uart_rx;
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Rx = 1'b1;
  logic       FIFO_Full = 1'b0;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic [2:0] Rx_Error;
  logic       Overrun;
  logic       RTS;
  logic       Rx_Busy;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] e;
    logic       o;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] last_data = '0;
  logic [2:0] last_err = '0;

  uart_rx #(.SYSCLK_RATE(3200000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .FIFO_Full(FIFO_Full), .Data_Out(Data_Out), .Data_Valid(Data_Valid),
    .Rx_Error(Rx_Error), .Overrun(Overrun), .RTS(RTS), .Rx_Busy(Rx_Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic bit_out(input logic v);
    Rx = v;
    wait_clk(32);
  endtask

  // Expected outcome derived from the frame contents: break wins over parity and frame errors.
  task automatic frame(input logic [7:0] d, input logic pflip, input logic [1:0] stops, input logic ff);
    logic p, brk;
    exp_t x;
    p = (^d) ^ pflip;
    brk = d == 8'h00 && !p && stops == 2'b00;
    x.d = d;
    x.e = brk ? 3'b001 : {stops != 2'b11, pflip, 1'b0};
    x.o = ff;
    FIFO_Full = ff;
    q.push_back(x);
    bit_out(1'b0);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_out(p);
    bit_out(stops[0]);
    bit_out(stops[1]);
  endtask

  always @(negedge Clk)
    if (Rst && (Data_Valid || Overrun)) begin
      if (q.size() == 0) chk("unexpected_strobe", {Data_Valid, Overrun}, 2'b00);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("strobe_kind", {Data_Valid, Overrun}, {~x.o, x.o});
        chk("data_out", Data_Out, x.d);
        chk("rx_error", Rx_Error, x.e);
        last_data = x.d;
        last_err = x.e;
      end
    end

  initial begin
    wait_clk(5);
    chk("reset_outs", {Data_Out, Data_Valid, Rx_Error, Overrun, RTS, Rx_Busy}, '0);
    Rst = 1'b1;
    wait_clk(3);
    chk("rts_ready", RTS, 1'b1);
    wait_clk(20);
    frame(8'hA5, 1'b0, 2'b11, 1'b0);
    frame(8'hAA, 1'b1, 2'b11, 1'b0);
    wait_clk(10);
    frame(8'h55, 1'b0, 2'b00, 1'b0);
    bit_out(1'b1);
    frame(8'h00, 1'b0, 2'b00, 1'b0);
    Rx = 1'b1;
    wait_clk(20);
    Rx = 1'b0;
    wait_clk(6);
    chk("no_rearm", Rx_Busy, 1'b0);
    wait_clk(4);
    Rx = 1'b1;
    wait_clk(40);
    frame(8'h5A, 1'b0, 2'b11, 1'b0);
    wait_clk(10);
    for (int n = 0; n < 16; n++) begin
      frame(8'($urandom), $urandom_range(0, 3) == 0, {1'b1, 1'($urandom_range(0, 4) != 0)}, $urandom_range(0, 3) == 0);
      wait_clk($urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 50));
    end
    wait_clk(40);
    Rx = 1'b0;
    wait_clk(10);
    Rx = 1'b1;
    wait_clk(60);
    chk("glitch_idle", Rx_Busy, 1'b0);
    chk("glitch_err", Rx_Error, last_err);
    chk("glitch_data", Data_Out, last_data);
    FIFO_Full = 1'b1;
    wait_clk(3);
    chk("rts_full", RTS, 1'b0);
    frame(8'h3C, 1'b0, 2'b11, 1'b1);
    chk("rts_full_end", RTS, 1'b0);
    FIFO_Full = 1'b0;
    wait_clk(10);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    wait_clk(10);
    chk("busy_mid", Rx_Busy, 1'b1);
    Rst = 1'b0;
    wait_clk(1);
    chk("reset_mid", {Data_Out, Data_Valid, Rx_Error, Overrun, RTS, Rx_Busy}, '0);
    Rx = 1'b1;
    wait_clk(3);
    Rst = 1'b1;
    wait_clk(100);
    chk("post_reset_idle", {Rx_Busy, Data_Out, Rx_Error}, '0);
    frame(8'h01, 1'b0, 2'b11, 1'b0);
    frame(8'hFE, 1'b0, 2'b11, 1'b0);
    Rx = 1'b1;
    wait_clk(100);
    chk("pending", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
